// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller (RUN, DSTALL, ISTALL, HALT); outputs combinational, zero latency.
// A data miss freezes every stage. Optional perf counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] id_rs,
   input  logic [3:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [3:0] ex_rd,
   input  logic       br_taken,
   input  logic       id_halt,
   input  logic       imiss_stall,
   input  logic       dmiss_stall,
   output logic       pc_wen,
   output logic       fd_wen,
   output logic       dx_wen,
   output logic       xm_wen,
   output logic       mw_wen,
   output logic       fd_flush,
   output logic       dx_flush,
   output logic       halted,
   output logic [1:0] state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_cycles
`endif
);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DSTALL = 2'd1;
   localparam logic [1:0] ST_ISTALL = 2'd2;
   localparam logic [1:0] ST_HALT   = 2'd3;

   logic [1:0] r_state;
   logic       r_pre_istall;
   logic [2:0] r_drain;

   logic       w_load_use;
   logic [1:0] w_eff;
   logic [1:0] w_next;
   logic       w_pre_next;
   logic       w_drain_inc;
   logic       w_pc, w_fd, w_dx, w_xm, w_mw;
   logic       w_fd_flush, w_dx_flush;

   assign w_load_use = ex_memread & (ex_rd != 4'd0) &
                       ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

   // Once the data miss clears, DSTALL behaves as the state it interrupted for that cycle.
   assign w_eff = (r_state == ST_DSTALL) ? (r_pre_istall ? ST_ISTALL : ST_RUN) : r_state;

   always_comb begin
      w_pc        = 1'b1;
      w_fd        = 1'b1;
      w_dx        = 1'b1;
      w_xm        = 1'b1;
      w_mw        = 1'b1;
      w_fd_flush  = 1'b0;
      w_dx_flush  = 1'b0;
      w_next      = w_eff;
      w_pre_next  = r_pre_istall;
      w_drain_inc = 1'b0;
      if (dmiss_stall) begin
         w_pc = 1'b0;
         w_fd = 1'b0;
         w_dx = 1'b0;
         w_xm = 1'b0;
         w_mw = 1'b0;
         if (w_eff != ST_HALT) begin
            w_next     = ST_DSTALL;
            w_pre_next = (w_eff == ST_ISTALL);
         end
      end else begin
         case (w_eff)
            ST_HALT: begin
               w_pc        = 1'b0;
               w_fd_flush  = 1'b1;
               w_drain_inc = 1'b1;
            end
            ST_RUN, ST_ISTALL: begin
               if (w_load_use) begin
                  w_pc       = 1'b0;
                  w_fd       = 1'b0;
                  w_dx_flush = 1'b1;
               end else if (br_taken) begin
                  w_fd_flush = 1'b1;
                  w_next     = ST_RUN;
               end else if (w_eff == ST_ISTALL) begin
                  w_pc       = 1'b0;
                  w_fd_flush = 1'b1;
                  w_next     = imiss_stall ? ST_ISTALL : ST_RUN;
               end else if (imiss_stall) begin
                  w_next = ST_ISTALL;
               end else if (id_halt) begin
                  w_next = ST_HALT;
               end
            end
            default: w_next = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_RUN;
         r_pre_istall <= 1'b0;
         r_drain      <= 3'd0;
      end else begin
         r_state      <= w_next;
         r_pre_istall <= w_pre_next;
         if (w_drain_inc && (r_drain != 3'd4))
            r_drain <= r_drain + 3'd1;
      end
   end

   assign pc_wen   = rst & w_pc;
   assign fd_wen   = rst & w_fd;
   assign dx_wen   = rst & w_dx;
   assign xm_wen   = rst & w_xm;
   assign mw_wen   = rst & w_mw;
   assign fd_flush = rst & w_fd_flush;
   assign dx_flush = rst & w_dx_flush;
   assign halted   = rst & (r_state == ST_HALT) & (r_drain == 3'd4);
   assign state    = r_state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [15:0] r_stall_cycles;
   logic [15:0] r_flush_cycles;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= 16'd0;
         r_flush_cycles <= 16'd0;
      end else if (r_state != ST_HALT) begin
         if (!w_pc && (r_stall_cycles != 16'hFFFF))
            r_stall_cycles <= r_stall_cycles + 16'd1;
         if ((w_fd_flush || w_dx_flush) && (r_flush_cycles != 16'hFFFF))
            r_flush_cycles <= r_flush_cycles + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] id_rs = 4'd0, id_rt = 4'd0, ex_rd = 4'd0;
   logic       id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
   logic       br_taken = 1'b0, id_halt = 1'b0, imiss_stall = 1'b0, dmiss_stall = 1'b0;
   logic       pc_wen, fd_wen, dx_wen, xm_wen, mw_wen, fd_flush, dx_flush, halted;
   logic [1:0] state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [15:0] stall_cycles, flush_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd), .br_taken(br_taken), .id_halt(id_halt),
      .imiss_stall(imiss_stall), .dmiss_stall(dmiss_stall),
      .pc_wen(pc_wen), .fd_wen(fd_wen), .dx_wen(dx_wen), .xm_wen(xm_wen), .mw_wen(mw_wen),
      .fd_flush(fd_flush), .dx_flush(dx_flush), .halted(halted), .state(state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // wen order {pc,fd,dx,xm,mw}; flush order {fd,dx}
   task automatic expect_out(input string tag, input logic [4:0] wen, input logic [1:0] fl,
                             input logic [1:0] st, input logic hl);
      #1;
      check({tag, "/wen"},    {11'd0, pc_wen, fd_wen, dx_wen, xm_wen, mw_wen}, {11'd0, wen});
      check({tag, "/flush"},  {14'd0, fd_flush, dx_flush}, {14'd0, fl});
      check({tag, "/state"},  {14'd0, state}, {14'd0, st});
      check({tag, "/halted"}, {15'd0, halted}, {15'd0, hl});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 4'd0; id_rt = 4'd0; ex_rd = 4'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
      br_taken = 1'b0; id_halt = 1'b0; imiss_stall = 1'b0; dmiss_stall = 1'b0;
   endtask

   task automatic load_use_rs3();
      ex_memread = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_uses_rs = 1'b1;
   endtask

   initial begin
      idle();
      #2 rst = 1'b0;
      expect_out("reset", 5'b00000, 2'b00, 2'd0, 1'b0);
      #8 rst = 1'b1;
      expect_out("post_reset", 5'b11111, 2'b00, 2'd0, 1'b0);
      tick();
      expect_out("run_idle", 5'b11111, 2'b00, 2'd0, 1'b0);

      load_use_rs3();
      expect_out("lu_rs", 5'b00111, 2'b01, 2'd0, 1'b0);
      tick();
      idle();
      expect_out("lu_one_cycle", 5'b11111, 2'b00, 2'd0, 1'b0);
      ex_memread = 1'b1; ex_rd = 4'd5; id_rt = 4'd5; id_uses_rt = 1'b1;
      expect_out("lu_rt", 5'b00111, 2'b01, 2'd0, 1'b0);
      id_uses_rt = 1'b0;
      expect_out("lu_rt_unused", 5'b11111, 2'b00, 2'd0, 1'b0);
      idle();
      ex_memread = 1'b1; ex_rd = 4'd0; id_rs = 4'd0; id_uses_rs = 1'b1;
      expect_out("lu_r0", 5'b11111, 2'b00, 2'd0, 1'b0);
      tick();

      load_use_rs3(); br_taken = 1'b1;
      expect_out("lu_vs_br", 5'b00111, 2'b01, 2'd0, 1'b0);
      tick();
      idle(); br_taken = 1'b1;
      expect_out("br_after_lu", 5'b11111, 2'b10, 2'd0, 1'b0);
      tick();

      idle(); imiss_stall = 1'b1;
      expect_out("imiss_run", 5'b11111, 2'b00, 2'd0, 1'b0);
      tick();
      expect_out("istall", 5'b01111, 2'b10, 2'd2, 1'b0);
      dmiss_stall = 1'b1;
      expect_out("dmiss_c0", 5'b00000, 2'b00, 2'd2, 1'b0);
      for (int k = 1; k < 5; k++) begin
         tick();
         expect_out($sformatf("dmiss_c%0d", k), 5'b00000, 2'b00, 2'd1, 1'b0);
      end
      tick();
      dmiss_stall = 1'b0;
      expect_out("dmiss_release", 5'b01111, 2'b10, 2'd1, 1'b0);
      tick();
      expect_out("istall_resumed", 5'b01111, 2'b10, 2'd2, 1'b0);
      imiss_stall = 1'b0;
      expect_out("istall_last", 5'b01111, 2'b10, 2'd2, 1'b0);
      tick();
      expect_out("istall_to_run", 5'b11111, 2'b00, 2'd0, 1'b0);

      imiss_stall = 1'b1;
      tick();
      br_taken = 1'b1;
      expect_out("br_in_istall", 5'b11111, 2'b10, 2'd2, 1'b0);
      tick();
      idle();
      expect_out("br_istall_to_run", 5'b11111, 2'b00, 2'd0, 1'b0);

      id_halt = 1'b1;
      expect_out("halt_req", 5'b11111, 2'b00, 2'd0, 1'b0);
      tick();
      id_halt = 1'b0;
      for (int k = 0; k < 8; k++) begin
         dmiss_stall = (k == 2 || k == 3);
         br_taken    = (k == 7);
         expect_out($sformatf("drain_%0d", k), dmiss_stall ? 5'b00000 : 5'b01111,
                    dmiss_stall ? 2'b00 : 2'b10, 2'd3, (k >= 6));
         tick();
      end
      idle();

      #2 rst = 1'b0;
      expect_out("rst_mid_halt", 5'b00000, 2'b00, 2'd0, 1'b0);
      #2 rst = 1'b1;
      tick();
      expect_out("after_halt_rst", 5'b11111, 2'b00, 2'd0, 1'b0);

      imiss_stall = 1'b1;
      tick();
      dmiss_stall = 1'b1;
      tick();
      expect_out("pre_rst_dstall", 5'b00000, 2'b00, 2'd1, 1'b0);
      #2 rst = 1'b0;
      expect_out("rst_mid_dstall", 5'b00000, 2'b00, 2'd0, 1'b0);
      idle();
      #2 rst = 1'b1;
      tick();
      expect_out("after_dstall_rst", 5'b11111, 2'b00, 2'd0, 1'b0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
      check("perf_stall_zero", stall_cycles, 16'd0);
      check("perf_flush_zero", flush_cycles, 16'd0);
      load_use_rs3();
      tick();
      idle();
      tick();
      check("perf_stall_one", stall_cycles, 16'd1);
      check("perf_flush_one", flush_cycles, 16'd1);
      dmiss_stall = 1'b1;
      for (int k = 0; k < 65540; k++) @(posedge clk);
      #1;
      check("perf_stall_sat", stall_cycles, 16'hFFFF);
      tick();
      tick();
      check("perf_stall_hold", stall_cycles, 16'hFFFF);
      check("perf_flush_hold", flush_cycles, 16'd1);
      idle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  4  source register numbers of the instruction in decode.
- id_uses_rs, id_uses_rt  in  1  decode instruction reads rs / rt.
- ex_memread  in  1  instruction in execute is a load.
- ex_rd  in  4  destination register of the instruction in execute.
- br_taken  in  1  taken branch resolved in decode this cycle.
- id_halt  in  1  HLT instruction is in decode.
- imiss_stall  in  1  fetch memory busy.
- dmiss_stall  in  1  data memory busy.
- pc_wen, fd_wen, dx_wen, xm_wen, mw_wen  out  1  write enables for the PC and each pipeline register.
- fd_flush, dx_flush  out  1  load NOP into F/D or D/X.
- halted  out  1  pipeline drained after HLT.
- state  out  2  current FSM state.

Function
REQ-002 SHALL implement a registered FSM: RUN=0, DSTALL=1, ISTALL=2, HALT=3; outputs SHALL be combinational from state and inputs.
REQ-003 SHALL compute load_use = ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-004 Per-cycle priority SHALL be: dmiss_stall > load_use > br_taken > imiss_stall > id_halt.
REQ-005 dmiss_stall=1 in any state: all wen=0 and both flushes=0 (full freeze); next state DSTALL; DSTALL returns to the pre-miss state (RUN or ISTALL, held in a 1-bit register) in the cycle after dmiss_stall falls; HALT SHALL remain HALT.
REQ-006 load_use in RUN/ISTALL: pc_wen=0, fd_wen=0, dx_flush=1, dx_wen=xm_wen=mw_wen=1; br_taken and id_halt SHALL be ignored that cycle; no state change.
REQ-007 br_taken without load_use: fd_flush=1, all wen=1 (pc_wen=1 even in ISTALL, to redirect); ISTALL SHALL go to RUN; id_halt SHALL be ignored.
REQ-008 imiss_stall in RUN: next state ISTALL; in ISTALL: pc_wen=0, fd_wen=1, fd_flush=1, remaining wen=1; ISTALL->RUN the cycle after imiss_stall=0.
REQ-009 id_halt in RUN with no higher-priority event: next state HALT.
REQ-010 In HALT: pc_wen=0, fd_flush=1, all other wen=1; a 3-bit drain counter SHALL increment per non-frozen cycle and saturate at 4.
REQ-011 halted SHALL be 1 iff state=HALT and drain counter=4; HALT SHALL only exit through reset.
REQ-012 With no event in RUN: all wen=1, flushes=0.

Reset
REQ-013 rst=0 SHALL immediately force state=RUN, drain counter=0, all wen=0, flushes=0, halted=0, independent of clk.
REQ-014 After rst rises, the first rising edge SHALL operate per REQ-012, including reset asserted mid-stall or mid-drain.

Configuration
REQ-015 Macro PIPE_HAZARD_CTRL_PERF_EN defined: 16-bit outputs stall_cycles (counts cycles with pc_wen=0 outside HALT) and flush_cycles (counts cycles with fd_flush|dx_flush outside HALT); both saturate at 0xFFFF and reset to 0. Macro undefined: neither port nor counter exists, and all other behaviour is identical.

Verification
REQ-016 ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> exactly one cycle with pc_wen=0, fd_wen=0, dx_flush=1; with ex_rd=0 -> no stall.
REQ-017 Same-cycle load_use and br_taken -> fd_flush=0, dx_flush=1; next cycle with br_taken=1 and no hazard -> fd_flush=1.
REQ-018 dmiss_stall high for 5 cycles during ISTALL -> all wen=0 for 5 cycles, state=1; ISTALL resumes on the next cycle.
REQ-019 id_halt=1 in RUN -> state=3 next cycle; halted=1 after 4 drain cycles; a 2-cycle dmiss_stall during the drain delays halted by 2 cycles.
REQ-020 rst pulled low mid-HALT between clock edges -> outputs clear at once, state=0; with PIPE_HAZARD_CTRL_PERF_EN, stall_cycles at 0xFFFF stays 0xFFFF under continued stalls.
